// File: rtl/serial_rx.sv
// -----------------------------------------------------------------------------
// serial_rx
//
// Oversampling asynchronous serial receiver (UART style, 8N1 by default).
// The rx_i line is brought into the clk domain through a two-flop
// synchronizer. Frames are reassembled LSB first. Each completed word is
// presented on a one-entry valid/ready output buffer.
//
// Optional feature: define SERIAL_RX_PARITY_EN to insert one even-parity bit
// between the data bits and the stop bit. When the macro is undefined,
// parity_err_o is tied low.
//
// Parameters:
//   DATA_W        data bits per frame (1..16)
//   CLKS_PER_BIT  clk cycles per bit period (even, >= 4)
//
// Ports:
//   clk           system clock, all logic on the rising edge
//   rst_n         asynchronous active-low reset
//   rx_i          serial line, idle high, asynchronous to clk
//   data_o        received word, LSB = first data bit
//   valid_o       data_o holds an unconsumed word
//   ready_i       consumer takes data_o when valid_o && ready_i
//   frame_err_o   one-cycle pulse: stop bit sampled low
//   overrun_o     one-cycle pulse: word completed while buffer full (dropped)
//   parity_err_o  one-cycle pulse: parity mismatch at the stop sample
// -----------------------------------------------------------------------------
module serial_rx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              frame_err_o,
    output logic              overrun_o,
    output logic              parity_err_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_W + 1);

    // The START state counts half a bit so that every later sample
    // lands in the middle of its bit cell.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              rx_prev_q, rx_prev_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;
    logic              word_done;
    logic              rx_s;

`ifdef SERIAL_RX_PARITY_EN
    logic              par_q, par_d;
    logic              parity_err_q, parity_err_d;
`endif

    assign rx_s = sync2_q;

    always_comb begin
        sync1_d     = rx_i;
        sync2_d     = sync1_q;
        rx_prev_d   = rx_s;
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        // A handshake empties the buffer unless a new word loads below.
        valid_d     = valid_q & ~ready_i;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        word_done   = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                cnt_d     = '0;
                bit_cnt_d = '0;
                // Needs a real falling edge; a line stuck low (break) is ignored.
                if (rx_prev_q && !rx_s) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    // A high sample at mid-start is a glitch: drop it silently.
                    state_d = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d = '0;
                    // Shift right so the first received bit ends up at the LSB.
                    shift_d             = shift_q >> 1;
                    shift_d[DATA_W-1]   = rx_s;
                    bit_cnt_d           = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

`ifdef SERIAL_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    par_d   = rx_s;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif

            S_STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (!rx_s) begin
                        frame_err_d = 1'b1;
                    end
`ifdef SERIAL_RX_PARITY_EN
                    // Even parity: data bits plus parity bit XOR to zero.
                    if (^{shift_q, par_q}) begin
                        parity_err_d = 1'b1;
                    end
                    word_done = rx_s & ~(^{shift_q, par_q});
`else
                    word_done = rx_s;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Load into the output buffer if it is empty or being drained this
        // cycle; otherwise keep the held word and flag the loss.
        if (word_done) begin
            if (!valid_q || ready_i) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            rx_prev_q   <= 1'b1;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            rx_prev_q   <= rx_prev_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef SERIAL_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err_o = parity_err_q;
`else
    assign parity_err_o = 1'b0;
`endif

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;

endmodule

// File: doc/serial_rx.md
Name: serial_rx

Overview:
- Asynchronous serial receiver (UART-style, 8N1 by default): the receive end of the team's serial byte link.
- Oversamples a single `rx_i` line and reassembles frames into parallel words.
- Presents each word on a one-entry valid/ready output buffer.
- Sits between the board-level serial pin and the on-chip consumer inside the `main` hierarchy.

Parameters:
DATA_W, 8, data bits per frame (1..16)
CLKS_PER_BIT, 16, clk cycles per bit period (even, >= 4)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
rx_i  input  1  serial line, idle high, asynchronous to clk
data_o  output  DATA_W  received word, LSB = first data bit
valid_o  output  1  data_o holds an unconsumed word
ready_i  input  1  consumer accepts data_o when valid_o && ready_i
frame_err_o  output  1  one-cycle pulse: stop bit sampled low
overrun_o  output  1  one-cycle pulse: word completed while buffer full, new word dropped
parity_err_o  output  1  one-cycle pulse on parity mismatch (see Optional Feature)

Behaviour:
- Reset (rst_n low, async): all outputs 0 (data_o = 0); FSM = IDLE; counters = 0; both synchronizer flops = 1 (line idle).
- rx_i passes through a 2-flop synchronizer; all logic uses the synced value `rx_s`.
- FSM states: IDLE, START, DATA, (PARITY), STOP.
- IDLE -> START: on falling edge of rx_s (previous 1, current 0). Bit counter clears.
- START:
  - Wait CLKS_PER_BIT/2 cycles, then sample at mid-bit.
  - Sample 0: go to DATA.
  - Sample 1: glitch; return to IDLE with no error.
- DATA:
  - Sample every CLKS_PER_BIT cycles (mid-bit).
  - Shift samples in LSB first; after DATA_W samples go to PARITY (if enabled) or STOP.
- STOP: sample after CLKS_PER_BIT cycles.
  - Sample 1: word completes.
  - Sample 0: frame_err_o pulses 1 cycle; word discarded; go to IDLE.
  - A new start is detected only after rx_s returns high, since IDLE requires a falling edge (e.g. after a break).
- Word complete, same cycle as the stop sample:
  - Buffer empty, or valid_o && ready_i this cycle: load data_o; valid_o = 1 next cycle.
  - Buffer full and ready_i = 0: overrun_o pulses; buffered word retained unchanged.
- Latency: valid_o rises exactly 2 + CLKS_PER_BIT/2 + (DATA_W+1)*CLKS_PER_BIT + 1 cycles after rx_i falls (defaults: 155). Add CLKS_PER_BIT when PARITY_EN is defined.
- Output buffer rules:
  - Handshake completes on valid_o && ready_i; valid_o drops next cycle unless a new word loads that same cycle.
  - data_o stable while valid_o && !ready_i.
  - ready_i is ignored while valid_o = 0.
- FSM returns to IDLE right after STOP, so back-to-back frames are supported with zero idle bits.
- Reset mid-frame: partial word discarded; no error pulse; output buffer cleared.
- Counters are sized $clog2(CLKS_PER_BIT) and $clog2(DATA_W+1); no wrap occurs inside a state.

Optional Feature:
- Macro: SERIAL_RX_PARITY_EN
- Defined:
  - PARITY state inserted after DATA; one even-parity bit sampled mid-bit.
  - Even parity: XOR of data bits and parity bit = 0.
  - Mismatch: parity_err_o pulses 1 cycle when STOP is sampled; word discarded; no overrun evaluation.
  - If the stop bit is also low, both frame_err_o and parity_err_o pulse.
- Undefined: no PARITY state; parity_err_o tied 0.

Test Plan:
- Reset: assert rst_n low mid-frame, release -> data_o = 0, valid_o = 0, no error pulses; next clean frame 0x3C received correctly.
- Single frame 0xA5, defaults, ready_i = 1 -> valid_o high for exactly 1 cycle, 155 cycles after rx_i falls; data_o = 0xA5.
- Back-to-back 0x01, 0xFF, 0x80 with zero idle bits, ready_i = 1 -> three valid pulses spaced 160 cycles; data_o = 0x01, 0xFF, 0x80.
- ready_i = 0, send 0x11 then 0x22 -> data_o holds 0x11; overrun_o pulses once at 0x22's stop sample; raise ready_i -> 0x11 accepted; valid_o drops.
- Stop bit forced 0 on frame 0x55 -> frame_err_o 1-cycle pulse; valid_o stays 0; line high 2 bits, then send 0x66 -> received OK.
- Start glitch of 4 cycles low -> no valid, no errors. With SERIAL_RX_PARITY_EN, frame 0x07 with parity bit 0 -> parity_err_o pulse, no valid.
